raster_to_block_seq: RTL and testbench

Streaming front end for the next-generation sequential compressor. It accepts an image one pixel per cycle in raster order over a valid/ready handshake and buffers BLK image rows in ping-pong strip banks. It re-emits the pixels one per cycle in block order (block-column major, row-major inside each BLK x BLK block) to the DCT/quantiser. It replaces whole-frame array loading with a parametrised, back-pressured stream and signals img_done at end of frame.

---
 rtl/raster_to_block_seq.sv | 237 +++++++++++++++++++++++
 tb/tb_raster_to_block_seq.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/raster_to_block_seq.sv
// raster_to_block_seq
// Accepts a frame in raster order (one pixel per handshake), collects BLK rows
// per strip in ping-pong banks, and re-emits each strip in block order:
// block columns left to right, row-major inside each BLK x BLK block.
// Optional build macro LEVEL_SHIFT_EN: input pixels are taken as unsigned
// PIX_W-1 bit values (top bit ignored) and stored minus 2^(PIX_W-2).
//
// state  | meaning
// -------+------------------------------------------------------------
// IDLE   | waiting for start_img; all counters and bank flags cleared
// ACTIVE | writer fills banks, reader drains full banks in block order
// DONE   | one cycle after the final output handshake; img_done high
module raster_to_block_seq #(
    parameter int IMG_W = 640,
    parameter int IMG_H = 480,
    parameter int BLK   = 8,
    parameter int PIX_W = 9
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_img,
    input  logic [PIX_W-1:0] pix_in,
    input  logic             pix_in_valid,
    output logic             pix_in_ready,
    output logic [PIX_W-1:0] blk_out,
    output logic             blk_out_valid,
    input  logic             blk_out_ready,
    output logic             blk_out_first,
    output logic             blk_out_last,
    output logic             img_done
);
    localparam int STRIP_PIX = BLK * IMG_W;
    localparam int NBC       = IMG_W / BLK;
    localparam int NSTRIP    = IMG_H / BLK;
    localparam int AW        = (STRIP_PIX > 1) ? $clog2(STRIP_PIX) : 1;
    localparam int RW        = (BLK > 1) ? $clog2(BLK) : 1;
    localparam int BW        = (NBC > 1) ? $clog2(NBC) : 1;
    localparam int SW        = (NSTRIP > 0) ? $clog2(NSTRIP + 1) : 1;

    localparam logic [AW-1:0] WR_LAST    = AW'(STRIP_PIX - 1);
    localparam logic [RW-1:0] RC_LAST    = RW'(BLK - 1);
    localparam logic [BW-1:0] BC_LAST    = BW'(NBC - 1);
    localparam logic [SW-1:0] STRIPS     = SW'(NSTRIP);
    localparam logic [SW-1:0] STRIP_LAST = SW'(NSTRIP - 1);

    if (BLK < 2 || (BLK & (BLK - 1)) != 0) begin : g_bad_blk
        $error("raster_to_block_seq: BLK must be a power of 2 and at least 2");
    end
    if (IMG_W < BLK || (IMG_W % BLK) != 0) begin : g_bad_w
        $error("raster_to_block_seq: IMG_W must be a multiple of BLK");
    end
    if (IMG_H < BLK || (IMG_H % BLK) != 0) begin : g_bad_h
        $error("raster_to_block_seq: IMG_H must be a multiple of BLK");
    end
    if (PIX_W < 2) begin : g_bad_pix
        $error("raster_to_block_seq: PIX_W must be at least 2");
    end

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACTIVE,
        S_DONE
    } state_t;

    state_t           state;
    logic [1:0]       full;
    logic [1:0]       full_set;
    logic [1:0]       full_clr;
    logic             wr_bank;
    logic [AW-1:0]    wr_addr;
    logic [SW-1:0]    wr_strip;
    logic             wr_done;
    logic             wr_fire;
    logic             rd_bank;
    logic [RW-1:0]    rd_r;
    logic [RW-1:0]    rd_c;
    logic [BW-1:0]    rd_bc;
    logic [AW-1:0]    rd_addr;
    logic             rd_issue;
    logic             rd_strip_end;
    logic             out_strip_end;
    logic             out_bank;
    logic [SW-1:0]    acc_strip;
    logic             out_fire;
    logic             frame_end;
    logic [PIX_W-1:0] pix_w;

    logic [PIX_W-1:0] mem [2][STRIP_PIX];

`ifdef LEVEL_SHIFT_EN
    localparam logic [PIX_W-1:0] LS_OFF = {2'b01, {(PIX_W-2){1'b0}}};
    assign pix_w = {1'b0, pix_in[PIX_W-2:0]} - LS_OFF;
`else
    assign pix_w = pix_in;
`endif

    assign wr_done      = (wr_strip == STRIPS);
    assign pix_in_ready = (state == S_ACTIVE) && !full[wr_bank] && !wr_done;
    assign wr_fire      = pix_in_valid && pix_in_ready;

    // The memory read register is the output register, so a read is only
    // issued when the output slot is empty or being drained this cycle.
    assign out_fire     = blk_out_valid && blk_out_ready;
    assign rd_issue     = (state == S_ACTIVE) && full[rd_bank]
                          && (!blk_out_valid || blk_out_ready);
    assign rd_strip_end = (rd_r == RC_LAST) && (rd_c == RC_LAST) && (rd_bc == BC_LAST);
    assign rd_addr      = AW'(rd_r) * AW'(IMG_W) + AW'(rd_bc) * AW'(BLK) + AW'(rd_c);

    // A bank is released only once its final pixel has left downstream.
    assign full_set  = (wr_fire && wr_addr == WR_LAST) ? (2'b01 << wr_bank) : 2'b00;
    assign full_clr  = (out_fire && out_strip_end) ? (2'b01 << out_bank) : 2'b00;
    assign frame_end = out_fire && out_strip_end && (acc_strip == STRIP_LAST);

    // Frame sequencing and the end-of-frame pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= S_IDLE;
            img_done <= 1'b0;
        end else begin
            img_done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start_img) state <= S_ACTIVE;
                end
                S_ACTIVE: begin
                    if (frame_end) begin
                        state    <= S_DONE;
                        img_done <= 1'b1;
                    end
                end
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    // Writer position: address inside the current bank and strip count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_bank  <= 1'b0;
            wr_addr  <= '0;
            wr_strip <= '0;
        end else if (state != S_ACTIVE) begin
            wr_bank  <= 1'b0;
            wr_addr  <= '0;
            wr_strip <= '0;
        end else if (wr_fire) begin
            if (wr_addr == WR_LAST) begin
                wr_addr  <= '0;
                wr_bank  <= ~wr_bank;
                wr_strip <= wr_strip + 1'b1;
            end else begin
                wr_addr <= wr_addr + 1'b1;
            end
        end
    end

    // Bank-full flags; set and clear always target different banks.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            full <= 2'b00;
        end else if (state != S_ACTIVE) begin
            full <= 2'b00;
        end else begin
            full <= (full | full_set) & ~full_clr;
        end
    end

    // Strip bank storage, written in raster order.
    always_ff @(posedge clk) begin
        if (wr_fire) mem[wr_bank][wr_addr] <= pix_w;
    end

    // Output pixel register, loaded by the synchronous bank read.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            blk_out <= '0;
        end else if (rd_issue) begin
            blk_out <= mem[rd_bank][rd_addr];
        end
    end

    // Reader: block-order address walk, output valid and tags.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_bank       <= 1'b0;
            rd_r          <= '0;
            rd_c          <= '0;
            rd_bc         <= '0;
            blk_out_valid <= 1'b0;
            blk_out_first <= 1'b0;
            blk_out_last  <= 1'b0;
            out_strip_end <= 1'b0;
            out_bank      <= 1'b0;
            acc_strip     <= '0;
        end else if (state != S_ACTIVE) begin
            rd_bank       <= 1'b0;
            rd_r          <= '0;
            rd_c          <= '0;
            rd_bc         <= '0;
            blk_out_valid <= 1'b0;
            blk_out_first <= 1'b0;
            blk_out_last  <= 1'b0;
            out_strip_end <= 1'b0;
            out_bank      <= 1'b0;
            acc_strip     <= '0;
        end else begin
            if (rd_issue) begin
                blk_out_valid <= 1'b1;
                blk_out_first <= (rd_r == '0) && (rd_c == '0);
                blk_out_last  <= (rd_r == RC_LAST) && (rd_c == RC_LAST);
                out_strip_end <= rd_strip_end;
                out_bank      <= rd_bank;
                if (rd_c == RC_LAST) begin
                    rd_c <= '0;
                    if (rd_r == RC_LAST) begin
                        rd_r <= '0;
                        if (rd_bc == BC_LAST) begin
                            rd_bc   <= '0;
                            rd_bank <= ~rd_bank;
                        end else begin
                            rd_bc <= rd_bc + 1'b1;
                        end
                    end else begin
                        rd_r <= rd_r + 1'b1;
                    end
                end else begin
                    rd_c <= rd_c + 1'b1;
                end
            end else if (out_fire) begin
                blk_out_valid <= 1'b0;
            end
            if (out_fire && out_strip_end) acc_strip <= acc_strip + 1'b1;
        end
    end

endmodule

// File: tb/tb_raster_to_block_seq.sv
// Bench for raster_to_block_seq on a 16x32 frame with 8x8 blocks.
// Expected output order is derived from the output index by division,
// expected pixel values from the raster index.
`timescale 1ns/1ps
module tb_raster_to_block_seq;
    localparam int IMG_W = 16;
    localparam int IMG_H = 32;
    localparam int BLK   = 8;
    localparam int PIX_W = 9;
    localparam int NPIX  = IMG_W * IMG_H;
    localparam int STRIP = BLK * IMG_W;
    localparam int BPIX  = BLK * BLK;

    logic             clk = 1'b0;
    logic             rst;
    logic             start_img;
    logic [PIX_W-1:0] pix_in;
    logic             pix_in_valid;
    logic             pix_in_ready;
    logic [PIX_W-1:0] blk_out;
    logic             blk_out_valid;
    logic             blk_out_ready;
    logic             blk_out_first;
    logic             blk_out_last;
    logic             img_done;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    raster_to_block_seq #(
        .IMG_W(IMG_W),
        .IMG_H(IMG_H),
        .BLK  (BLK),
        .PIX_W(PIX_W)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .start_img    (start_img),
        .pix_in       (pix_in),
        .pix_in_valid (pix_in_valid),
        .pix_in_ready (pix_in_ready),
        .blk_out      (blk_out),
        .blk_out_valid(blk_out_valid),
        .blk_out_ready(blk_out_ready),
        .blk_out_first(blk_out_first),
        .blk_out_last (blk_out_last),
        .img_done     (img_done)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic logic [PIX_W-1:0] raw_of(input int idx, input int pat);
        logic [PIX_W-1:0] v;
        if (pat == 0) v = PIX_W'(idx % 256);
        else          v = PIX_W'(idx % 512);
        return v;
    endfunction

    function automatic logic [PIX_W-1:0] exp_of(input logic [PIX_W-1:0] raw);
`ifdef LEVEL_SHIFT_EN
        return {1'b0, raw[PIX_W-2:0]} - PIX_W'(128);
`else
        return raw;
`endif
    endfunction

    function automatic int raster_of(input int k);
        int s, rem, bc, r, c;
        s   = k / STRIP;
        rem = k % STRIP;
        bc  = rem / BPIX;
        r   = (rem % BPIX) / BLK;
        c   = rem % BLK;
        return (s * BLK + r) * IMG_W + bc * BLK + c;
    endfunction

    // mode 0: plain, 1: hold downstream until both banks full,
    // 2: extra start pulses mid-frame, 3: reset at input pixel 100
    task automatic run_frame(input string name, input int in_pct, input int out_pct,
                             input int pat, input int mode);
        int in_idx, out_idx, cyc, last_hs, done_cnt, strip0_cyc, full_cyc, rel_cyc;
        logic stall;
        logic [PIX_W-1:0] held;
        bit released;
        in_idx = 0; out_idx = 0; cyc = 0; last_hs = -10; done_cnt = 0;
        strip0_cyc = -10; full_cyc = -10; rel_cyc = -10;
        stall = 1'b0; held = '0; released = 1'b0;
        pix_in_valid = 1'b0;
        blk_out_ready = 1'b0;
        start_img = 1'b1;
        @(negedge clk);
        start_img = 1'b0;
        while (cyc < 20000) begin
            if (out_idx == NPIX && cyc > last_hs + 3) break;
            if (mode == 3 && in_idx == 100) begin
                rst = 1'b1;
                pix_in_valid = 1'b0;
                @(negedge clk);
                chk({name, " rst ready"}, pix_in_ready, 0);
                chk({name, " rst valid"}, blk_out_valid, 0);
                chk({name, " rst data"}, blk_out, 0);
                rst = 1'b0;
                @(negedge clk);
                chk({name, " post-rst ready"}, pix_in_ready, 0);
                chk({name, " post-rst done"}, img_done, 0);
                return;
            end
            if (stall) begin
                chk({name, " hold valid"}, blk_out_valid, 1);
                chk({name, " hold data"}, blk_out, held);
            end
            if (img_done) begin
                done_cnt++;
                chk({name, " done timing"}, cyc, last_hs + 1);
            end
            if (cyc == strip0_cyc + 1) chk({name, " latency low"}, blk_out_valid, 0);
            if (cyc == strip0_cyc + 2) chk({name, " latency high"}, blk_out_valid, 1);
            if (cyc == rel_cyc + 1) chk({name, " ready back"}, pix_in_ready, 1);
            if (mode == 1 && full_cyc >= 0 && cyc > full_cyc && cyc <= full_cyc + 4)
                chk({name, " ready dropped"}, pix_in_ready, 0);

            start_img = (mode == 2 && (cyc == 70 || cyc == 400));
            pix_in_valid = (in_idx < NPIX) && (int'($urandom_range(99)) < in_pct);
            pix_in = pix_in_valid ? raw_of(in_idx, pat) : PIX_W'($urandom);
            if (mode == 1 && !released) begin
                blk_out_ready = 1'b0;
                if (full_cyc >= 0 && cyc >= full_cyc + 5) begin
                    released = 1'b1;
                    blk_out_ready = 1'b1;
                end
            end else begin
                blk_out_ready = (int'($urandom_range(99)) < out_pct);
            end

            if (pix_in_valid && pix_in_ready) begin
                in_idx++;
                if (in_idx == STRIP) strip0_cyc = cyc;
                if (mode == 1 && in_idx == 2 * STRIP) full_cyc = cyc;
            end
            if (blk_out_valid && blk_out_ready) begin
                chk({name, " data"}, blk_out, exp_of(raw_of(raster_of(out_idx), pat)));
                chk({name, " first"}, blk_out_first, (out_idx % BPIX) == 0);
                chk({name, " last"}, blk_out_last, (out_idx % BPIX) == BPIX - 1);
                if (out_pct == 100 && mode != 1 && (out_idx % STRIP) != 0)
                    chk({name, " no bubble"}, cyc, last_hs + 1);
                out_idx++;
                last_hs = cyc;
                if (mode == 1 && out_idx == STRIP) begin
                    chk({name, " ready before"}, pix_in_ready, 0);
                    rel_cyc = cyc;
                end
            end
            stall = blk_out_valid && !blk_out_ready;
            held  = blk_out;
            cyc++;
            @(negedge clk);
        end
        start_img = 1'b0;
        pix_in_valid = 1'b0;
        blk_out_ready = 1'b0;
        chk({name, " in count"}, in_idx, NPIX);
        chk({name, " out count"}, out_idx, NPIX);
        chk({name, " done count"}, done_cnt, 1);
        chk({name, " idle ready"}, pix_in_ready, 0);
    endtask

    initial begin
        rst = 1'b1;
        start_img = 1'b0;
        pix_in = '0;
        pix_in_valid = 1'b0;
        blk_out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            pix_in_valid  = 1'($urandom);
            pix_in        = PIX_W'($urandom);
            blk_out_ready = 1'($urandom);
            start_img     = (i == 1);
            chk("reset ready", pix_in_ready, 0);
            chk("reset valid", blk_out_valid, 0);
            chk("reset data", blk_out, 0);
            chk("reset first", blk_out_first, 0);
            chk("reset last", blk_out_last, 0);
            chk("reset done", img_done, 0);
        end
        @(negedge clk);
        rst = 1'b0;
        start_img = 1'b0;
        pix_in_valid = 1'b1;
        @(negedge clk);
        chk("idle ready", pix_in_ready, 0);
        @(negedge clk);
        chk("idle valid", blk_out_valid, 0);
        pix_in_valid = 1'b0;

        run_frame("plain",    100, 100, 0, 0);
        run_frame("backpres", 100, 100, 0, 1);
        run_frame("random",    50,  50, 1, 0);
        run_frame("restart",  100, 100, 0, 2);
        run_frame("abort",    100, 100, 0, 3);
        run_frame("fresh",    100, 100, 1, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
